// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - EX/MEM latch, data-memory access FSM, branch resolution, MEM/WB register
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] EX_ALU_result,
  input  logic [31:0] EX_rs2_data,
  input  logic [31:0] EX_pc,
  input  logic        EX_zero,
  input  logic        EX_branch,
  input  logic        EX_memread,
  input  logic        EX_memtoreg,
  input  logic        EX_memwrite,
  input  logic        EX_regwrite,
  input  logic        EX_unconditional_jmp,
  input  logic [4:0]  EX_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [4:0]  EX_MEM_rd,
  output logic        EX_MEM_regwrite,
  output logic        EX_MEM_memread,
  output logic        EX_MEM_memtoreg,
  output logic [31:0] EX_MEM_ALU_result,
  output logic        MEM_stall,
  output logic        MEM_flush,
  output logic [4:0]  MEM_WB_rd,
  output logic [31:0] MEM_WB_result,
  output logic        MEM_WB_regwrite,
  output logic        MEM_misaligned,
  output logic        MEM_bus_error
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] ex_mem_rs2;
  logic [31:0] ex_mem_pc;
  logic        ex_mem_zero;
  logic        ex_mem_branch;
  logic        ex_mem_memwrite;
  logic        ex_mem_ujmp;

  logic        mem_op;
  logic        misaligned;
  logic        aligned_op;
  logic        timeout;
  logic        fault;
  logic [31:0] wb_result;

  assign mem_op     = EX_MEM_memread | ex_mem_memwrite;
  assign misaligned = mem_op & (EX_MEM_ALU_result[1:0] != 2'b00);
  assign aligned_op = mem_op & ~misaligned;
  assign fault      = misaligned | timeout;

  // Driven purely from the latch so an asynchronous reset drops the request at once.
  assign dmem_req   = aligned_op;
  assign dmem_we    = aligned_op & ex_mem_memwrite;
  assign dmem_addr  = EX_MEM_ALU_result;
  assign dmem_wdata = ex_mem_rs2;

  assign MEM_stall  = aligned_op & ~dmem_ready & ~timeout;
  assign MEM_flush  = (ex_mem_branch & ex_mem_zero) | ex_mem_ujmp;

  always_comb begin
    wb_result = EX_MEM_ALU_result;
    if (ex_mem_ujmp)
      wb_result = ex_mem_pc + 32'd4;
    else if (EX_MEM_memtoreg)
      wb_result = dmem_rdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (aligned_op && !dmem_ready) begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          timeout = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush outranks the stall hold so a redirect always squashes the younger op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EX_MEM_ALU_result <= '0;
      ex_mem_rs2        <= '0;
      ex_mem_pc         <= '0;
      ex_mem_zero       <= 1'b0;
      ex_mem_branch     <= 1'b0;
      EX_MEM_memread    <= 1'b0;
      EX_MEM_memtoreg   <= 1'b0;
      ex_mem_memwrite   <= 1'b0;
      EX_MEM_regwrite   <= 1'b0;
      ex_mem_ujmp       <= 1'b0;
      EX_MEM_rd         <= '0;
    end else if (MEM_flush) begin
      EX_MEM_ALU_result <= '0;
      ex_mem_rs2        <= '0;
      ex_mem_pc         <= '0;
      ex_mem_zero       <= 1'b0;
      ex_mem_branch     <= 1'b0;
      EX_MEM_memread    <= 1'b0;
      EX_MEM_memtoreg   <= 1'b0;
      ex_mem_memwrite   <= 1'b0;
      EX_MEM_regwrite   <= 1'b0;
      ex_mem_ujmp       <= 1'b0;
      EX_MEM_rd         <= '0;
    end else if (!MEM_stall) begin
      EX_MEM_ALU_result <= EX_ALU_result;
      ex_mem_rs2        <= EX_rs2_data;
      ex_mem_pc         <= EX_pc;
      ex_mem_zero       <= EX_zero;
      ex_mem_branch     <= EX_branch;
      EX_MEM_memread    <= EX_memread;
      EX_MEM_memtoreg   <= EX_memtoreg;
      ex_mem_memwrite   <= EX_memwrite;
      EX_MEM_regwrite   <= EX_regwrite;
      ex_mem_ujmp       <= EX_unconditional_jmp;
      EX_MEM_rd         <= EX_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEM_WB_rd       <= '0;
      MEM_WB_result   <= '0;
      MEM_WB_regwrite <= 1'b0;
    end else if (MEM_stall || fault) begin
      MEM_WB_rd       <= '0;
      MEM_WB_result   <= '0;
      MEM_WB_regwrite <= 1'b0;
    end else begin
      MEM_WB_rd       <= EX_MEM_rd;
      MEM_WB_result   <= wb_result;
      MEM_WB_regwrite <= EX_MEM_regwrite & (EX_MEM_rd != 5'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEM_misaligned <= 1'b0;
      MEM_bus_error  <= 1'b0;
    end else begin
      if (misaligned) MEM_misaligned <= 1'b1;
      if (timeout)    MEM_bus_error  <= 1'b1;
    end
  end

endmodule
